// File: rtl/rr_decode_arbiter.sv
// ============================================================================
// Module   : rr_decode_arbiter
// Purpose  : 4-way round-robin arbiter with hold-limit preemption and
//            registered one-hot / binary grant outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_decode_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       preempt
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_ptr;
   logic [1:0] w_ptr_nxt;
   logic [7:0] r_hold_cnt;
   logic [7:0] w_hold_nxt;
   logic [3:0] w_gnt_nxt;
   logic [1:0] w_idx_nxt;
   logic       w_valid_nxt;
   logic       w_preempt_nxt;

   logic       w_hold_lim;
   logic       w_release;
   logic [1:0] w_arb_ptr;
   logic [7:0] w_req_dbl;
   logic [3:0] w_rot;
   logic [1:0] w_off;
   logic       w_any;
   logic [1:0] w_win;

   assign w_hold_lim = (r_hold_cnt == c_hold_last);
   assign w_release  = (r_state == ST_GRANT) && (done || !req[gnt_idx] || w_hold_lim);

   // On a release the search starts just past the holder, so it ends up last.
   assign w_arb_ptr  = w_release ? (gnt_idx + 2'd1) : r_ptr;
   assign w_req_dbl  = {req, req};
   assign w_rot      = w_req_dbl[{1'b0, w_arb_ptr} +: 4];
   assign w_any      = |req;

   always_comb begin
      w_off = 2'd0;
      casez (w_rot)
         4'b???1: w_off = 2'd0;
         4'b??10: w_off = 2'd1;
         4'b?100: w_off = 2'd2;
         4'b1000: w_off = 2'd3;
         default: w_off = 2'd0;
      endcase
   end

   assign w_win = w_arb_ptr + w_off;

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold_cnt;
      w_gnt_nxt     = gnt;
      w_idx_nxt     = gnt_idx;
      w_valid_nxt   = gnt_valid;
      w_preempt_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_GRANT;
               w_idx_nxt   = w_win;
               w_gnt_nxt   = 4'b0001 << w_win;
               w_valid_nxt = 1'b1;
               w_hold_nxt  = 8'd0;
            end else begin
               w_gnt_nxt   = 4'b0000;
               w_valid_nxt = 1'b0;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_ptr_nxt     = gnt_idx + 2'd1;
               w_preempt_nxt = w_hold_lim && !done && req[gnt_idx];
               w_hold_nxt    = 8'd0;
               if (w_any) begin
                  w_idx_nxt   = w_win;
                  w_gnt_nxt   = 4'b0001 << w_win;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = 4'b0000;
                  w_valid_nxt = 1'b0;
               end
            end else begin
               w_hold_nxt = r_hold_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= 2'd0;
         r_hold_cnt <= 8'd0;
         gnt        <= 4'b0000;
         gnt_idx    <= 2'd0;
         gnt_valid  <= 1'b0;
         preempt    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_hold_cnt <= w_hold_nxt;
         gnt        <= w_gnt_nxt;
         gnt_idx    <= w_idx_nxt;
         gnt_valid  <= w_valid_nxt;
         preempt    <= w_preempt_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
// ============================================================================
// Module   : tb_rr_decode_arbiter
// Purpose  : Directed self-checking bench for rr_decode_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_decode_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int checks;
   int failures;

   rr_decode_arbiter #(.MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic [3:0] e_gnt,
                            input logic [1:0] e_idx, input logic e_valid,
                            input logic e_pre);
      chk({tag, ".gnt"},     8'(gnt),       8'(e_gnt));
      chk({tag, ".idx"},     8'(gnt_idx),   8'(e_idx));
      chk({tag, ".valid"},   8'(gnt_valid), 8'(e_valid));
      chk({tag, ".preempt"}, 8'(preempt),   8'(e_pre));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      req      = 4'b0000;
      done     = 1'b0;

      // Reset state
      step();
      step();
      chk_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_grant("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

      // First grant, ptr=0: requester 1 wins from 4'b1010
      req = 4'b1010;
      step();
      chk_grant("first_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Non-holder request changes leave the grant alone
      req = 4'b1110;
      step();
      chk_grant("nonholder_change", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b1010;

      // done hands over to requester 3 with no bubble
      done = 1'b1;
      step();
      done = 1'b0;
      chk_grant("done_handover", 4'b1000, 2'd3, 1'b1, 1'b0);

      // Holder drops with nobody else asking -> idle, gnt_idx holds
      req = 4'b0000;
      step();
      chk_grant("drop_to_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
      step();
      chk_grant("stay_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

      // ptr is now 0 (3+1): all requesting gives 0, then done rotates 1,2,3,0
      req = 4'b1111;
      step();
      chk_grant("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);
      done = 1'b1;
      step();
      chk_grant("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
      chk_grant("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
      step();
      chk_grant("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
      step();
      chk_grant("rot4", 4'b0001, 2'd0, 1'b1, 1'b0);
      done = 1'b0;

      // Sole requester 0: hold limit of 8 preempts and re-grants, twice
      req = 4'b0001;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk_grant($sformatf("hold_k%0d", k), 4'b0001, 2'd0, 1'b1, (k % 8) == 0);
      end

      // Hold limit coinciding with done and req drop: single release, no preempt
      for (int k = 1; k <= 7; k++) begin
         step();
      end
      chk_grant("pre_coincide", 4'b0001, 2'd0, 1'b1, 1'b0);
      done = 1'b1;
      req  = 4'b0000;
      step();
      done = 1'b0;
      chk_grant("coincide", 4'b0000, 2'd0, 1'b0, 1'b0);

      // ptr is now 1: from 4'b0011 requester 1 wins
      req = 4'b0011;
      step();
      chk_grant("ptr_after_limit", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Asynchronous reset between clock edges mid-grant
      #3;
      rst_n = 1'b0;
      #1;
      chk_grant("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      step();
      chk_grant("held_in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      req   = 4'b0100;
      step();
      chk_grant("grant_after_reset", 4'b0100, 2'd2, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rr_decode_arbiter.md
RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, maximum grant tenure in cycles (legal 2..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset; the single clock domain uses asynchronous, active-low reset.
REQ-004 SHALL have port req  input  4  request per requester; bit i = requester i, level-sensitive.
REQ-005 SHALL have port done  input  1  current holder releases the resource; sampled only while gnt_valid=1.
REQ-006 SHALL have port gnt  output  4  one-hot grant; all-zero when idle; registered.
REQ-007 SHALL have port gnt_idx  output  2  binary index of the current holder; registered; gnt equals the 2-to-4 decode of gnt_idx when gnt_valid=1.
REQ-008 SHALL have port gnt_valid  output  1  a grant is active; registered.
REQ-009 SHALL have port preempt  output  1  one-cycle pulse; tenure was force-ended by the hold limit.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one holder).
REQ-011 SHALL keep a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first asserted req wins.
REQ-012 In IDLE with req!=0 at edge N, SHALL enter GRANT so that gnt/gnt_idx/gnt_valid are asserted after edge N (1-cycle latency); the hold counter loads 0.
REQ-013 In IDLE with req==0, SHALL remain in IDLE with gnt=0, gnt_valid=0; gnt_idx holds its last value.
REQ-014 In GRANT, SHALL hold gnt stable until a release event; req changes of non-holders SHALL NOT affect the grant.
REQ-015 SHALL treat as a release event any of: done=1; req[holder]=0; hold counter == MAX_HOLD-1.
REQ-016 On a release, SHALL set ptr = holder+1 (mod 4), then re-arbitrate with the new ptr at the same edge: if any req is set, grant the winner with no idle bubble and reload the hold counter to 0; otherwise go to IDLE.
REQ-017 The releasing requester SHALL be eligible at lowest priority; if it is the only requester, it is re-granted.
REQ-018 The hold counter SHALL be 8 bits, increment once per GRANT cycle without a release, and never wrap, because a release at MAX_HOLD-1 always reloads it.
REQ-019 SHALL pulse preempt=1 for exactly one cycle when the release is caused solely by the hold limit (done=0 and req[holder]=1); else preempt=0.
REQ-020 When the hold limit, done and req drop coincide, SHALL treat the event as a single release, with preempt=0.
REQ-021 ptr SHALL change only on release events, never in IDLE.
REQ-022 No more than one gnt bit SHALL ever be asserted.

Reset
REQ-023 While rst_n=0, SHALL force state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, asynchronously.
REQ-024 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for clk.
REQ-025 After rst_n deasserts, the first grant SHALL follow REQ-012 with ptr=0.

Verification
REQ-026 Reset, then req=4'b1010 -> one cycle later gnt=4'b0010, gnt_idx=1, gnt_valid=1.
REQ-027 Holder 1 with req=4'b1010, pulse done -> next cycle gnt=4'b1000, idx=3, no idle bubble; ptr becomes 2.
REQ-028 req=4'b0001 held constant, done=0, MAX_HOLD=8 -> the grant lasts 8 cycles, preempt pulses once, requester 0 is re-granted immediately, and this repeats.
REQ-029 req=4'b1111 with done pulsed each grant -> grants rotate 0,1,2,3,0; each index appears exactly once per 4 grants.
REQ-030 Holder drops req with no other requests -> next cycle gnt=0, gnt_valid=0, state IDLE, ptr=holder+1.
REQ-031 Assert rst_n=0 between clock edges during a grant -> gnt=0 and gnt_valid=0 without a clock edge; after release, req=4'b0100 -> gnt=4'b0100.
